// File: rtl/link_frame_codec_pkg.sv
// Shared definitions for the framed link layer: default frame markers,
// the layout of the local status word, FSM state encodings and the
// check-byte helper used by both the transmitter and the receiver.
package link_frame_codec_pkg;

    // Default frame start marker and check-byte mask.
    localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;
    localparam logic [7:0] CHK_MASK_DEF  = 8'h5A;

    // Width of the delta-position field inside the status word.
    localparam int LD_POS_W = 5;

    // Local status word layout, MSB first:
    // bit 7 restart_tick, bit 6 score_press, bit 5 menu_start, bits 4:0 d_position.
    typedef struct packed {
        logic                restart_tick;
        logic                score_press;
        logic                menu_start;
        logic [LD_POS_W-1:0] d_position;
    } local_word_t;

    typedef enum logic [1:0] {
        TX_IDLE = 2'd0,
        TX_SYNC = 2'd1,
        TX_DATA = 2'd2,
        TX_CHK  = 2'd3
    } tx_state_t;

    typedef enum logic [1:0] {
        RX_HUNT = 2'd0,
        RX_DATA = 2'd1,
        RX_CHK  = 2'd2
    } rx_state_t;

    // Check byte carried after the data byte of every frame.
    function automatic logic [7:0] frame_check(input logic [7:0] data,
                                               input logic [7:0] mask);
        return data ^ mask;
    endfunction

endpackage

// File: rtl/link_frame_codec_if.sv
// Byte-level handshake between the link codec and the UART FIFO wrapper.
// master = codec side, slave = FIFO side.
interface link_frame_codec_if;
    logic [7:0] w_data;    // byte pushed into the TX FIFO
    logic       wr_uart;   // one-cycle push strobe
    logic       tx_full;   // TX FIFO full
    logic [7:0] r_data;    // head of RX FIFO (first-word-fall-through)
    logic       rd_uart;   // one-cycle pop strobe
    logic       rx_empty;  // RX FIFO empty

    modport master (
        output w_data,
        output wr_uart,
        output rd_uart,
        input  tx_full,
        input  r_data,
        input  rx_empty
    );

    modport slave (
        input  w_data,
        input  wr_uart,
        input  rd_uart,
        output tx_full,
        output r_data,
        output rx_empty
    );
endinterface

// File: rtl/link_frame_rx.sv
// Receive side of the framed link: hunts for the sync byte, captures the
// data byte, validates the check byte, and runs the silence watchdog that
// drops link_up and clears the remote word.
module link_frame_rx
    import link_frame_codec_pkg::*;
#(
    parameter int         TIMEOUT   = 6500000,
    parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEF,
    parameter logic [7:0] CHK_MASK  = CHK_MASK_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_empty,
    input  logic [7:0] r_data,
    output logic       rd_uart,
    output logic [7:0] remote_data,
    output logic       remote_strobe,
    output logic       link_up,
    output logic [7:0] err_count
);

    localparam int          WD_W     = 23;
    localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(TIMEOUT);
    localparam logic [WD_W-1:0] WD_LAST  = WD_W'(TIMEOUT - 1);

    rx_state_t       rx_state_r;
    logic [7:0]      rx_hold_r;
    logic [7:0]      remote_data_r;
    logic            remote_strobe_r;
    logic            link_up_r;
    logic [7:0]      err_count_r;
    logic [WD_W-1:0] wd_cnt_r;
    logic            pop_s;
    logic            good_s;

    assign rd_uart       = pop_s;
    assign remote_data   = remote_data_r;
    assign remote_strobe = remote_strobe_r;
    assign link_up       = link_up_r;
    assign err_count     = err_count_r;

    // Every byte at the FIFO head is consumed in every legal state.
    always_comb begin
        pop_s = 1'b0;
        case (rx_state_r)
            RX_HUNT, RX_DATA, RX_CHK: pop_s = ~rx_empty;
            default:                  pop_s = 1'b0;
        endcase
    end

    // A good frame is a popped check byte matching the held data byte.
    always_comb begin
        good_s = 1'b0;
        if (pop_s && (rx_state_r == RX_CHK) &&
            (r_data == frame_check(rx_hold_r, CHK_MASK))) begin
            good_s = 1'b1;
        end else begin
            good_s = 1'b0;
        end
    end

    // Hunt/data/check FSM with the strobe and saturating error counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_state_r      <= RX_HUNT;
            rx_hold_r       <= 8'h00;
            remote_strobe_r <= 1'b0;
            err_count_r     <= 8'h00;
        end else begin
            remote_strobe_r <= 1'b0;
            case (rx_state_r)
                RX_HUNT: begin
                    if (pop_s && (r_data == SYNC_BYTE)) begin
                        rx_state_r <= RX_DATA;
                    end
                end
                RX_DATA: begin
                    if (pop_s) begin
                        rx_hold_r  <= r_data;
                        rx_state_r <= RX_CHK;
                    end
                end
                RX_CHK: begin
                    if (pop_s) begin
                        if (good_s) begin
                            remote_strobe_r <= 1'b1;
                        end else if (err_count_r != 8'hFF) begin
                            err_count_r <= err_count_r + 8'd1;
                        end else begin
                            err_count_r <= err_count_r;
                        end
                        rx_state_r <= RX_HUNT;
                    end
                end
                default: begin
                    rx_state_r <= RX_HUNT;
                end
            endcase
        end
    end

    // Watchdog: a good frame reloads the link; silence for TIMEOUT cycles
    // drops it and zeroes the remote word. A good frame wins a tie.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wd_cnt_r      <= {WD_W{1'b0}};
            link_up_r     <= 1'b0;
            remote_data_r <= 8'h00;
        end else if (good_s) begin
            wd_cnt_r      <= {WD_W{1'b0}};
            link_up_r     <= 1'b1;
            remote_data_r <= rx_hold_r;
        end else if (wd_cnt_r == WD_LAST) begin
            wd_cnt_r      <= WD_LIMIT;
            link_up_r     <= 1'b0;
            remote_data_r <= 8'h00;
        end else if (wd_cnt_r != WD_LIMIT) begin
            wd_cnt_r      <= wd_cnt_r + {{(WD_W-1){1'b0}}, 1'b1};
        end else begin
            wd_cnt_r      <= wd_cnt_r;
        end
    end

endmodule

// File: rtl/link_frame_codec.sv
// Framed link layer top: sends the local status word as a sync/data/check
// frame every FRAME_GAP cycles and hands received bytes to link_frame_rx.
module link_frame_codec
    import link_frame_codec_pkg::*;
#(
    parameter int         FRAME_GAP = 65000,
    parameter int         TIMEOUT   = 6500000,
    parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEF,
    parameter logic [7:0] CHK_MASK  = CHK_MASK_DEF
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [7:0]                local_data,
    link_frame_codec_if.master        uart,
    output logic [7:0]                remote_data,
    output logic                      remote_strobe,
    output logic                      link_up,
    output logic [7:0]                err_count
);

    localparam int GAP_W = (FRAME_GAP > 2) ? $clog2(FRAME_GAP) : 1;
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(FRAME_GAP - 1);

    tx_state_t        tx_state_r;
    local_word_t      tx_hold_r;
    logic [GAP_W-1:0] gap_cnt_r;
    logic [GAP_W-1:0] gap_step_s;
    logic [7:0]       w_data_r;
    logic             wr_uart_r;

    assign uart.w_data  = w_data_r;
    assign uart.wr_uart = wr_uart_r;

    // Gap counter advance while a frame is in flight; it parks at the last
    // value so a late frame still starts the next one as soon as it ends.
    always_comb begin
        gap_step_s = gap_cnt_r;
        if (gap_cnt_r != GAP_LAST) begin
            gap_step_s = gap_cnt_r + {{(GAP_W-1){1'b0}}, 1'b1};
        end else begin
            gap_step_s = gap_cnt_r;
        end
    end

    // TX FSM: fixed-rate frame start, one registered push per byte,
    // each push held off while the TX FIFO reports full.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tx_state_r <= TX_IDLE;
            tx_hold_r  <= '0;
            gap_cnt_r  <= {GAP_W{1'b0}};
            w_data_r   <= 8'h00;
            wr_uart_r  <= 1'b0;
        end else begin
            wr_uart_r <= 1'b0;
            case (tx_state_r)
                TX_IDLE: begin
                    if (gap_cnt_r == GAP_LAST) begin
                        tx_hold_r  <= local_data;
                        gap_cnt_r  <= {GAP_W{1'b0}};
                        tx_state_r <= TX_SYNC;
                    end else begin
                        gap_cnt_r  <= gap_step_s;
                    end
                end
                TX_SYNC: begin
                    gap_cnt_r <= gap_step_s;
                    if (!uart.tx_full) begin
                        wr_uart_r  <= 1'b1;
                        w_data_r   <= SYNC_BYTE;
                        tx_state_r <= TX_DATA;
                    end
                end
                TX_DATA: begin
                    gap_cnt_r <= gap_step_s;
                    if (!uart.tx_full) begin
                        wr_uart_r  <= 1'b1;
                        w_data_r   <= tx_hold_r;
                        tx_state_r <= TX_CHK;
                    end
                end
                TX_CHK: begin
                    gap_cnt_r <= gap_step_s;
                    if (!uart.tx_full) begin
                        wr_uart_r  <= 1'b1;
                        w_data_r   <= frame_check(tx_hold_r, CHK_MASK);
                        tx_state_r <= TX_IDLE;
                    end
                end
                default: begin
                    tx_state_r <= TX_IDLE;
                end
            endcase
        end
    end

    link_frame_rx #(
        .TIMEOUT   (TIMEOUT),
        .SYNC_BYTE (SYNC_BYTE),
        .CHK_MASK  (CHK_MASK)
    ) u_rx (
        .clk           (clk),
        .rst           (rst),
        .rx_empty      (uart.rx_empty),
        .r_data        (uart.r_data),
        .rd_uart       (uart.rd_uart),
        .remote_data   (remote_data),
        .remote_strobe (remote_strobe),
        .link_up       (link_up),
        .err_count     (err_count)
    );

endmodule
